leaky_relu_wb: RTL and testbench

LEAKY_RELU_WB -- requirements
Module: leaky_relu_wb

---
 rtl/leaky_relu_wb.sv | 180 ++++++++++++++++++
 tb/tb_leaky_relu_wb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_relu_wb.sv
// Leaky-ReLU activation stage with unified-buffer write-back.
// Accepts up to num_rows Q8.8 samples per pass, applies a leaky ReLU
// (negative slope = leak_factor, Q8.8) through a two-stage pipeline and
// emits one buffer write per sample at contiguous addresses from base_addr.
module leaky_relu_wb #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_rows,
  input  logic [15:0]       leak_factor,
  input  logic              act_valid_in,
  input  logic [15:0]       act_data_in,
  output logic [15:0]       act_data_out,
  output logic              act_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Control state and latched pass configuration
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         rows_q, rows_d;
  logic [15:0]         leak_q, leak_d;
  logic [15:0]         idx_q, idx_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Stage 1: accepted sample, its full product and its target address
  logic                s1_valid_q, s1_valid_d;
  logic [15:0]         s1_x_q, s1_x_d;
  logic signed [31:0]  s1_prod_q, s1_prod_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;

  // Stage 2: registered write-back outputs
  logic                wr_en_q, wr_en_d;
  logic [15:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Helper signals
  logic                accept;
  logic                last_write;
  logic signed [31:0]  x_ext;
  logic signed [31:0]  leak_ext;
  logic signed [31:0]  shifted;
  logic [15:0]         act_result;

  // Sample acceptance, pass completion and the activation arithmetic
  always_comb begin
    accept     = (state_q == ST_RUN) && act_valid_in && (idx_q < rows_q);
    // Last write is on the bus, nothing behind it, and no sample left to take.
    last_write = wr_en_q && !s1_valid_q && (idx_q == rows_q);

    x_ext    = {{16{act_data_in[15]}}, act_data_in};
    leak_ext = {{16{leak_q[15]}}, leak_q};

    // Arithmetic shift floors toward -inf; clamp into the Q8.8 range.
    shifted = s1_prod_q >>> 8;
    if (!s1_x_q[15]) begin
      act_result = s1_x_q;
    end else if (shifted > 32'sd32767) begin
      act_result = 16'h7FFF;
    end else if (shifted < -32'sd32768) begin
      act_result = 16'h8000;
    end else begin
      act_result = shifted[15:0];
    end
  end

  // Next-state, configuration, pipeline and flag computation
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rows_d     = rows_q;
    leak_d     = leak_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q | (act_valid_in & ~accept);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            base_d  = base_addr;
            rows_d  = num_rows;
            leak_d  = leak_factor;
            idx_d   = 16'd0;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          idx_d = idx_q + 16'd1;
        end
        if (last_write) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);

    // Stage 1 holds zeros when idle so stage 2 outputs stay clean.
    s1_valid_d = accept;
    s1_x_d     = accept ? act_data_in : 16'd0;
    s1_prod_d  = accept ? (x_ext * leak_ext) : 32'sd0;
    s1_addr_d  = accept ? (base_q + ADDR_W'(idx_q)) : '0;

    wr_en_d = s1_valid_q;
    data_d  = s1_valid_q ? act_result : 16'd0;
    addr_d  = s1_valid_q ? s1_addr_q : '0;
  end

  // Single register bank for FSM, config, pipeline and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      rows_q     <= 16'd0;
      leak_q     <= 16'd0;
      idx_q      <= 16'd0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= 16'd0;
      s1_prod_q  <= 32'sd0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= 16'd0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      leak_q     <= leak_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_prod_q  <= s1_prod_d;
      s1_addr_q  <= s1_addr_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  assign act_data_out  = data_q;
  assign act_valid_out = wr_en_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_leaky_relu_wb.sv
// Directed bench for leaky_relu_wb: hand-computed writes are queued with
// the cycle they are due, and every clock the write port is compared.
module tb_leaky_relu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_rows;
  logic [15:0] leak_factor;
  logic        act_valid_in;
  logic [15:0] act_data_in;
  logic [15:0] act_data_out;
  logic        act_valid_out;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];

  leaky_relu_wb #(.ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .leak_factor  (leak_factor),
    .act_valid_in (act_valid_in),
    .act_data_in  (act_data_in),
    .act_data_out (act_data_out),
    .act_valid_out(act_valid_out),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock, then compare the write port with the queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("act_valid_out", {31'd0, act_valid_out}, 32'd1);
      chk("act_data_out", {16'd0, act_data_out}, {16'd0, e.data});
      chk("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
      $display("cyc %0d write data=%h addr=%h (expected %h @ %h)",
               cyc, act_data_out, wr_addr, e.data, e.addr);
    end else begin
      chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
      chk("act_valid_out_idle", {31'd0, act_valid_out}, 32'd0);
      chk("data_idle", {16'd0, act_data_out}, 32'd0);
      chk("addr_idle", {16'd0, wr_addr}, 32'd0);
    end
    chk("busy_and_done", {31'd0, busy & done}, 32'd0);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] a, input bit expect_write);
    act_valid_in = 1'b1;
    act_data_in  = x;
    if (expect_write) exp_q.push_back('{cyc + 2, y, a});
    step();
    act_valid_in = 1'b0;
    act_data_in  = 16'd0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] r, input logic [15:0] l);
    start       = 1'b1;
    base_addr   = b;
    num_rows    = r;
    leak_factor = l;
    step();
    start = 1'b0;
    $display("cyc %0d start base=%h rows=%0d leak=%h", cyc, b, r, l);
  endtask

  // Drain outstanding writes, then expect exactly one done cycle.
  task automatic finish_pass();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("writes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    step();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    step();
    chk("done_cleared", {31'd0, done}, 32'd0);
    $display("cyc %0d pass complete", cyc);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = 16'd0;
    num_rows     = 16'd0;
    leak_factor  = 16'd0;
    act_valid_in = 1'b0;
    act_data_in  = 16'd0;

    // Reset state
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    step();

    // Basic pass: back-to-back, mixed signs
    do_start(16'h0010, 16'd3, 16'h0019);
    chk("busy_run", {31'd0, busy}, 32'd1);
    send(16'h0180, 16'h0180, 16'h0010, 1'b1);
    send(16'hFE00, 16'hFFCE, 16'h0011, 1'b1);
    send(16'h0000, 16'h0000, 16'h0012, 1'b1);
    finish_pass();
    chk("no_overrun_p1", {31'd0, overrun}, 32'd0);

    // Negative saturation
    do_start(16'h0100, 16'd1, 16'h7FFF);
    send(16'h8000, 16'h8000, 16'h0100, 1'b1);
    finish_pass();

    // Unity slope
    do_start(16'h0100, 16'd1, 16'h0100);
    send(16'hFF80, 16'hFF80, 16'h0100, 1'b1);
    finish_pass();

    // Negative slope: positive saturation and small positive result
    do_start(16'h0200, 16'd2, 16'h8000);
    send(16'h8000, 16'h7FFF, 16'h0200, 1'b1);
    send(16'hFFFF, 16'h0080, 16'h0201, 1'b1);
    finish_pass();

    // Floor rounding of tiny negative products; max positive passthrough
    do_start(16'h0300, 16'd2, 16'h0019);
    send(16'hFFFF, 16'hFFFF, 16'h0300, 1'b1);
    send(16'h7FFF, 16'h7FFF, 16'h0301, 1'b1);
    finish_pass();

    // Address wrap-around
    do_start(16'hFFFE, 16'd4, 16'h0100);
    send(16'h0001, 16'h0001, 16'hFFFE, 1'b1);
    send(16'h0002, 16'h0002, 16'hFFFF, 1'b1);
    send(16'hFFFE, 16'hFFFE, 16'h0000, 1'b1);
    send(16'h0003, 16'h0003, 16'h0001, 1'b1);
    finish_pass();

    // Gapped inputs with a start pulse while busy
    do_start(16'h0040, 16'd3, 16'h0080);
    send(16'h0200, 16'h0200, 16'h0040, 1'b1);
    start = 1'b1; base_addr = 16'h0999; num_rows = 16'd7; leak_factor = 16'h0100;
    step();
    start = 1'b0;
    step();
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    send(16'hFC00, 16'hFE00, 16'h0041, 1'b1);
    step(); step();
    send(16'hFFFF, 16'hFFFF, 16'h0042, 1'b1);
    finish_pass();

    // Zero-row pass: done straight away, no writes
    do_start(16'h0AAA, 16'd0, 16'h0100);
    chk("rows0_done", {31'd0, done}, 32'd1);
    chk("rows0_busy", {31'd0, busy}, 32'd0);
    step();
    chk("rows0_done_cleared", {31'd0, done}, 32'd0);
    chk("rows0_overrun", {31'd0, overrun}, 32'd0);

    // Fourth valid in a three-row pass is dropped and flags overrun
    do_start(16'h0050, 16'd3, 16'h0100);
    send(16'h0001, 16'h0001, 16'h0050, 1'b1);
    send(16'h0002, 16'h0002, 16'h0051, 1'b1);
    send(16'h0003, 16'h0003, 16'h0052, 1'b1);
    send(16'h1234, 16'h0000, 16'h0000, 1'b0);
    chk("overrun_extra", {31'd0, overrun}, 32'd1);
    finish_pass();
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset clears overrun; a valid in IDLE sets it again
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("overrun_rst", {31'd0, overrun}, 32'd0);
    send(16'h0042, 16'h0000, 16'h0000, 1'b0);
    chk("overrun_idle", {31'd0, overrun}, 32'd1);
    step();

    // Reset with two samples in flight
    do_start(16'h0060, 16'd3, 16'h0100);
    send(16'h0011, 16'h0011, 16'h0060, 1'b1);
    send(16'h0022, 16'h0022, 16'h0061, 1'b1);
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    step(); step();

    // Fresh pass after the mid-pass reset
    do_start(16'h0070, 16'd2, 16'h0040);
    send(16'hFF00, 16'hFFC0, 16'h0070, 1'b1);
    send(16'h0100, 16'h0100, 16'h0071, 1'b1);
    finish_pass();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
